ipm_distributed_fifo_sync: RTL

//  Single-clock FIFO built on the distributed (select_ram) storage style, async-read LUT RAM array plus pointer/flag control.

---
 rtl/ipm_distributed_fifo_sync.sv | 112 +++++++++++
 1 files changed

// File: rtl/ipm_distributed_fifo_sync.sv
// Single-clock FIFO over an async-read distributed RAM array, with registered flags,
// water level, almost flags, overflow/underflow pulses and optional first-word-fall-through.
module ipm_distributed_fifo_sync #(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 2**ADDR_WIDTH - 2,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   water_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] LVL_AE   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  head_vld_q, head_vld_d;
  logic                  wr_full_q, wr_full_d;
  logic                  rd_empty_q, rd_empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ov_q, ov_d;
  logic                  un_q, un_d;
  logic                  wr_acc, rd_acc, ram_rd, ram_nonempty;

  always_comb begin
    wr_acc       = wr_en & ~wr_full_q;
    rd_acc       = rd_en & ~rd_empty_q;
    ram_nonempty = (wr_ptr_q != rd_ptr_q);
    ram_rd       = rd_acc;
    head_vld_d   = 1'b0;
    // FWFT: the output register is an extra storage slot, refilled from RAM
    // whenever it is empty or being popped this edge.
    if (FWFT != 0) begin
      ram_rd     = ram_nonempty & (~head_vld_q | rd_acc);
      head_vld_d = ram_rd | (head_vld_q & ~rd_acc);
    end
    wr_ptr_d  = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = ram_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rd_data_d = ram_rd ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : rd_data_q;
    level_d   = level_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
    wr_full_d = (level_d == LVL_FULL);
    if (FWFT != 0) rd_empty_d = ~head_vld_d;
    else           rd_empty_d = (level_d == '0);
    af_d = (level_d >= LVL_AF);
    ae_d = (level_d <= LVL_AE);
    ov_d = wr_en & wr_full_q;
    un_d = rd_en & rd_empty_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      head_vld_q <= 1'b0;
      wr_full_q  <= 1'b0;
      rd_empty_q <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ov_q       <= 1'b0;
      un_q       <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      head_vld_q <= head_vld_d;
      wr_full_q  <= wr_full_d;
      rd_empty_q <= rd_empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ov_q       <= ov_d;
      un_q       <= un_d;
    end
  end

  assign wr_full      = wr_full_q;
  assign almost_full  = af_q;
  assign rd_data      = rd_data_q;
  assign rd_empty     = rd_empty_q;
  assign almost_empty = ae_q;
  assign water_level  = level_q;
  assign overflow     = ov_q;
  assign underflow    = un_q;

endmodule
